mem_port_arbiter: RTL and testbench

Shares the single unified memory port between the instruction-fetch (IF) stage and the data-access (MEM) stage of the 5-stage RISC-V `DataPath`. It sequences one outstanding memory transaction at a time and gives MEM priority over IF. It generates the per-stage stall signals that freeze the pipeline while an access is pending. A watchdog counter aborts transactions that the memory never acknowledges and records the fault in a sticky flag.

---
 rtl/mem_port_arbiter_if.sv | 24 ++
 rtl/mem_port_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Unified memory port bus: the arbiter drives the request side as master,
// the memory answers with a single-cycle ack and read data as slave.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_be;
  logic                  mem_ack;
  logic [DATA_W-1:0]     mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one memory port between instruction fetch and data access.
// One transaction at a time, data has priority, and a watchdog aborts
// transactions the memory never acknowledges (sticky err_timeout).
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_valid,
  output logic                stall_if,
  output logic                stall_mem,
  mem_port_arbiter_if.master  mem,
  output logic                err_timeout
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, DATA, FETCH, RESP} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]     mem_be_q, mem_be_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                if_valid_q, if_valid_d;
  logic                d_valid_q, d_valid_d;
  logic                err_q, err_d;
  logic                tmo_hit;

  // Watchdog increment that sticks at TIMEOUT instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // The count reaches TIMEOUT on this edge if no ack is seen.
  assign tmo_hit = (cnt_q == CNT_LAST);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: grant from IDLE (data first), finish on ack or timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (d_req)       state_d = DATA;
        else if (if_req) state_d = FETCH;
      end
      DATA, FETCH: begin
        if (mem.mem_ack || tmo_hit) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values: latch attributes on grant, capture read
  // data or zero on completion, raise the one-cycle valid pulse.
  always_comb begin
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    cnt_d       = cnt_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (d_req) begin
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_be_d    = d_be;
        end else if (if_req) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          mem_be_d    = '1;
        end
      end
      DATA, FETCH: begin
        if (mem.mem_ack) begin
          mem_req_d = 1'b0;
          if (state_q == DATA) begin
            d_rdata_d = mem.mem_rdata;
            d_valid_d = 1'b1;
          end else begin
            if_rdata_d = mem.mem_rdata;
            if_valid_d = 1'b1;
          end
        end else begin
          cnt_d = sat_inc(cnt_q);
          if (tmo_hit) begin
            mem_req_d = 1'b0;
            err_d     = 1'b1;
            if (state_q == DATA) begin
              d_rdata_d = '0;
              d_valid_d = 1'b1;
            end else begin
              if_rdata_d = '0;
              if_valid_d = 1'b1;
            end
          end
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath and flag registers; reset discards any in-flight transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
      err_q       <= err_d;
    end
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign mem.mem_be    = mem_be_q;
  assign if_rdata      = if_rdata_q;
  assign if_valid      = if_valid_q;
  assign d_rdata       = d_rdata_q;
  assign d_valid       = d_valid_q;
  assign err_timeout   = err_q;
  assign stall_if      = if_req & ~if_valid_q;
  assign stall_mem     = d_req & ~d_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// Bench for mem_port_arbiter: table of single transactions plus hand-written
// sequences for priority, spurious acks and reset during a fetch.
module tb_mem_port_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, d_req, d_we;
  logic [AW-1:0] if_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic [3:0]    d_be;
  logic [DW-1:0] if_rdata, d_rdata;
  logic          if_valid, d_valid, stall_if, stall_mem, err_timeout;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mem ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .mem(mem), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard of expected completions, popped on each valid pulse.
  typedef struct {
    bit          is_data;
    logic [31:0] rdata;
    bit          err;
  } exp_t;
  exp_t sb_q[$];

  always @(negedge clk) begin
    exp_t e;
    if (if_valid || d_valid) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_valid", {if_valid, d_valid}, 2'b00);
      end else begin
        e = sb_q.pop_front();
        check("sb_port", {if_valid, d_valid}, e.is_data ? 2'b01 : 2'b10);
        check("sb_rdata", e.is_data ? d_rdata : if_rdata, e.rdata);
        check("sb_err", err_timeout, e.err);
      end
    end
  end

  // Memory responder: automatic ack after mem_lat cycles (0 = never), or
  // manual mode where man_ack/man_rdata are applied after the next edge.
  bit          auto_mem = 1'b1;
  int          mem_lat = 1;
  logic [31:0] mem_rdata_v = '0;
  bit          man_ack = 1'b0;
  logic [31:0] man_rdata = '0;
  int          ack_cyc = 0;

  initial begin
    mem.mem_ack   = 1'b0;
    mem.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (auto_mem) begin
        if (mem.mem_ack) begin
          mem.mem_ack = 1'b0;
          ack_cyc     = 0;
        end else if (mem.mem_req) begin
          ack_cyc++;
          if (mem_lat != 0 && ack_cyc == mem_lat) begin
            mem.mem_ack   = 1'b1;
            mem.mem_rdata = mem_rdata_v;
          end
        end else begin
          ack_cyc = 0;
        end
      end else begin
        mem.mem_ack   = man_ack;
        mem.mem_rdata = man_rdata;
      end
    end
  end

  typedef struct {
    bit          dreq;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          lat;
    logic [31:0] rdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;
  vec_t vecs[8];

  task automatic apply_vec(input vec_t v, input int idx);
    int n_req = 0;
    bit done  = 1'b0;
    bit first = 1'b1;
    mem_lat     = v.lat;
    mem_rdata_v = v.rdata;
    sb_q.push_back('{v.dreq, v.exp_rdata, v.exp_err});
    @(negedge clk);
    if (v.dreq) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_be = v.be;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (mem.mem_req) begin
        n_req++;
        if (first) begin
          first = 1'b0;
          check($sformatf("v%0d_mem_we", idx), mem.mem_we, v.dreq ? v.we : 1'b0);
          check($sformatf("v%0d_mem_addr", idx), mem.mem_addr, v.addr);
          check($sformatf("v%0d_mem_be", idx), mem.mem_be, v.dreq ? v.be : 4'hF);
          if (v.dreq && v.we) check($sformatf("v%0d_mem_wdata", idx), mem.mem_wdata, v.wdata);
          check($sformatf("v%0d_stall_busy", idx), v.dreq ? stall_mem : stall_if, 1'b1);
        end
      end
      if (v.dreq ? d_valid : if_valid) begin
        done = 1'b1;
        check($sformatf("v%0d_stall_at_valid", idx), v.dreq ? stall_mem : stall_if, 1'b0);
        d_req  = 1'b0;
        if_req = 1'b0;
      end
    end
    if (!done) begin
      check($sformatf("v%0d_valid_seen", idx), 1'b0, 1'b1);
      d_req  = 1'b0;
      if_req = 1'b0;
    end
    check($sformatf("v%0d_req_cycles", idx), n_req, (v.lat == 0) ? TMO : v.lat);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected completion");
    $fatal(1);
  end

  initial begin
    int d_at, fg_at, i_at;
    bit first_d, stall_bad;

    vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         4'h0, 2, 32'h0050_0093, 32'h0050_0093, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0,         4'hF, 1, 32'h1234_5678, 32'h1234_5678, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 3, 32'hA5A5_0000, 32'hA5A5_0000, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0204, 32'h0,         4'hF, 8, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_0014, 32'h0,         4'h0, 7, 32'h00A0_0113, 32'h00A0_0113, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_0208, 32'h0,         4'hF, 0, 32'h9999_9999, 32'h0000_0000, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 32'h0000_0018, 32'h0,         4'h0, 2, 32'h0000_0013, 32'h0000_0013, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 32'h0000_010C, 32'h0000_ABCD, 4'h3, 1, 32'h0000_0000, 32'h0000_0000, 1'b1};

    reset = 1'b0; if_req = 1'b1; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; d_be = '0;

    // Reset state and stalls following requests during reset.
    @(negedge clk);
    check("rst_mem_req", mem.mem_req, 1'b0);
    check("rst_mem_attr", {mem.mem_we, mem.mem_addr, mem.mem_be}, '0);
    check("rst_mem_wdata", mem.mem_wdata, '0);
    check("rst_rdata", {if_rdata, d_rdata}, '0);
    check("rst_valid_err", {if_valid, d_valid, err_timeout}, '0);
    check("rst_stall_if", stall_if, 1'b1);
    check("rst_stall_mem_lo", stall_mem, 1'b0);
    d_req = 1'b1;
    #1;
    check("rst_stall_mem_hi", stall_mem, 1'b1);
    d_req = 1'b0; if_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) apply_vec(vecs[i], i);

    // Simultaneous store and fetch: data first, fetch two cycles after d_valid.
    mem_lat = 2; mem_rdata_v = 32'h1111_2222;
    sb_q.push_back('{1'b1, 32'h1111_2222, 1'b1});
    sb_q.push_back('{1'b0, 32'h1111_2222, 1'b1});
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_be = 4'hF;
    if_req = 1'b1; if_addr = 32'h20;
    d_at = -1; fg_at = -1; i_at = -1; first_d = 1'b1; stall_bad = 1'b0;
    for (int k = 0; k < 60 && i_at < 0; k++) begin
      @(negedge clk);
      if (mem.mem_req && d_at < 0 && first_d) begin
        first_d = 1'b0;
        check("pri_first_we", mem.mem_we, 1'b1);
        check("pri_first_addr", mem.mem_addr, 32'h100);
        check("pri_first_wdata", mem.mem_wdata, 32'hDEAD_BEEF);
      end
      if (mem.mem_req && d_at >= 0 && fg_at < 0) begin
        fg_at = k;
        check("pri_fetch_we", mem.mem_we, 1'b0);
        check("pri_fetch_addr", mem.mem_addr, 32'h20);
        check("pri_fetch_be", mem.mem_be, 4'hF);
      end
      if (d_valid) begin
        d_at  = k;
        d_req = 1'b0;
      end
      if (if_valid) begin
        i_at = k;
        check("pri_stall_if_at_valid", stall_if, 1'b0);
        if_req = 1'b0;
      end else if (!stall_if) begin
        stall_bad = 1'b1;
      end
    end
    check("pri_fetch_done", i_at >= 0, 1'b1);
    check("pri_fetch_grant_gap", fg_at - d_at, 2);
    check("pri_stall_if_held", stall_bad, 1'b0);
    if (i_at < 0) if_req = 1'b0;

    // Spurious acks in RESP and IDLE are ignored.
    @(negedge clk);
    auto_mem = 1'b0; man_ack = 1'b0;
    @(negedge clk);
    sb_q.push_back('{1'b1, 32'h0000_0077, 1'b1});
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_be = 4'hF;
    man_ack = 1'b1; man_rdata = 32'h0000_0077;
    @(negedge clk);
    check("spur_req_up", mem.mem_req, 1'b1);
    man_ack = 1'b1; man_rdata = 32'h0000_0BAD;
    @(negedge clk);
    check("spur_resp_valid", d_valid, 1'b1);
    d_req = 1'b0; man_ack = 1'b0;
    @(negedge clk);
    check("spur_resp_hold_rdata", d_rdata, 32'h0000_0077);
    check("spur_resp_no_req", {mem.mem_req, d_valid, if_valid}, 3'b000);
    man_ack = 1'b1; man_rdata = 32'h0000_0BA2;
    @(negedge clk);
    man_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("spur_idle_no_req", {mem.mem_req, d_valid, if_valid}, 3'b000);
    check("spur_idle_d_rdata", d_rdata, 32'h0000_0077);
    check("spur_idle_if_rdata", if_rdata, 32'h1111_2222);

    // Reset one cycle into a fetch, then re-grant of the held request.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h40;
    @(negedge clk);
    check("rmid_req_up", mem.mem_req, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rmid_mem_req", mem.mem_req, 1'b0);
    check("rmid_mem_attr", {mem.mem_we, mem.mem_addr, mem.mem_be, mem.mem_wdata}, '0);
    check("rmid_rdata", {if_rdata, d_rdata}, '0);
    check("rmid_flags", {if_valid, d_valid, err_timeout}, 3'b000);
    check("rmid_stall_if", stall_if, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    sb_q.push_back('{1'b0, 32'h0400_0013, 1'b0});
    man_ack = 1'b1; man_rdata = 32'h0400_0013;
    @(negedge clk);
    check("rmid_regrant_req", mem.mem_req, 1'b1);
    check("rmid_regrant_addr", mem.mem_addr, 32'h40);
    man_ack = 1'b0;
    @(negedge clk);
    check("rmid_if_valid", if_valid, 1'b1);
    if_req = 1'b0;
    @(negedge clk);
    @(negedge clk);

    check("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
